txn_draw_ctrl: RTL and testbench

//  Sequencer directly upstream of the transaction row drawer and downstream of the ledger logic.

---
 rtl/txn_draw_pkg.sv | 39 +++
 rtl/row_clear_sweep.sv | 52 +++++
 rtl/txn_draw_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_txn_draw_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/txn_draw_pkg.sv
// txn_draw_pkg
//   Shared types and constants for the transaction row draw sequencer:
//   controller state encoding, ledger status codes, plot colours and the
//   status-to-colour mapping used when a transaction is accepted.
//   Optional feature macro: TXN_ROW_CLEAR_EN (row blanking before each draw).
package txn_draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ARM,
        ST_DRAW,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        STATUS_PENDING  = 2'd0,
        STATUS_VERIFIED = 2'd1,
        STATUS_REJECTED = 2'd2,
        STATUS_OTHER    = 2'd3
    } status_t;

    // Colours are {R,G,B}.
    localparam logic [2:0] COLOUR_PENDING  = 3'b110;
    localparam logic [2:0] COLOUR_VERIFIED = 3'b010;
    localparam logic [2:0] COLOUR_REJECTED = 3'b100;
    localparam logic [2:0] COLOUR_OTHER    = 3'b111;
    localparam logic [2:0] COLOUR_BLACK    = 3'b000;

    function automatic logic [2:0] status_colour(input logic [1:0] status);
        case (status_t'(status))
            STATUS_PENDING:  return COLOUR_PENDING;
            STATUS_VERIFIED: return COLOUR_VERIFIED;
            STATUS_REJECTED: return COLOUR_REJECTED;
            default:         return COLOUR_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/row_clear_sweep.sv
// row_clear_sweep
//   Raster counter that blanks one row slot: x runs 0..SCREEN_W-1 fastest,
//   y runs top_y .. top_y+ROW_PITCH-1. Used only when TXN_ROW_CLEAR_EN is
//   defined.
// Ports
//   clk, reset : clock, synchronous active-high reset
//   start      : reload both counters to the first pixel of the row
//   step       : advance one pixel this cycle
//   top_y      : first screen line of the row being blanked
//   x, y       : current pixel coordinate
//   last       : current pixel is the final one of the row
module row_clear_sweep #(
    parameter int SCREEN_W  = 320,
    parameter int ROW_PITCH = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic [7:0] top_y,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic       last
);

    localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
    localparam logic [7:0] Y_LAST = 8'(ROW_PITCH - 1);

    logic [8:0] x_cnt;
    logic [7:0] y_cnt;

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (step) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 8'd1;
            end else begin
                x_cnt <= x_cnt + 9'd1;
            end
        end
    end

    assign x    = x_cnt;
    assign y    = top_y + y_cnt;
    assign last = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

endmodule

// File: rtl/txn_draw_ctrl.sv
// txn_draw_ctrl
//   Sequencer between the ledger logic and the transaction row drawer.
//   Accepts one transaction per valid/ready handshake, assigns it the next
//   row slot, optionally blanks the row, re-arms and enables the drawer and
//   forwards its pixels to the VGA plot port in a status-dependent colour.
//   Optional feature macro: TXN_ROW_CLEAR_EN (adds CLEAR state + sweeper).
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   txn_valid/txn_status/ready : transaction handshake and 2-bit status
//   draw_resetn, draw_enable   : drawer re-arm (active low) and enable
//   draw_start_x/y             : drawer origin for the current slot
//   draw_x/y, draw_done        : drawer pixel coordinate and completion
//   vga_x/y/colour/plot        : registered plot port
//   busy                       : controller not in IDLE
//   timeout_err                : sticky DRAW-timeout flag
module txn_draw_ctrl #(
    parameter int BASE_Y       = 24,
    parameter int ROW_PITCH    = 20,
    parameter int NUM_ROWS     = 10,
    parameter int SCREEN_W     = 320,
    parameter int DRAW_TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txn_valid,
    input  logic [1:0] txn_status,
    output logic       txn_ready,
    output logic       draw_resetn,
    output logic       draw_enable,
    output logic [8:0] draw_start_x,
    output logic [7:0] draw_start_y,
    input  logic [8:0] draw_x,
    input  logic [7:0] draw_y,
    input  logic       draw_done,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       timeout_err
);

    import txn_draw_pkg::*;

    localparam int SLOT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int TO_W   = $clog2(DRAW_TIMEOUT + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_ROWS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(DRAW_TIMEOUT - 1);

    state_t            state, state_next;
    logic [SLOT_W-1:0] slot;
    logic [2:0]        colour;
    logic [TO_W-1:0]   draw_cnt;
    logic              accept;
    logic              timeout_hit;
    logic [8:0]        sweep_x;
    logic [7:0]        sweep_y;
    logic              clear_last;

    assign accept       = txn_valid && txn_ready;
    assign draw_start_x = 9'd0;
    assign draw_start_y = 8'(BASE_Y) + 8'(slot) * 8'(ROW_PITCH);

    // Abort on the DRAW_TIMEOUT-th DRAW cycle; a simultaneous draw_done wins.
    assign timeout_hit = (state == ST_DRAW) && (draw_cnt == TO_LAST) && !draw_done;

`ifdef TXN_ROW_CLEAR_EN
    logic       sweep_step;
    logic [7:0] sweep_top_y;

    assign sweep_step  = (state == ST_CLEAR);
    assign sweep_top_y = draw_start_y - 8'd8;

    row_clear_sweep #(
        .SCREEN_W  (SCREEN_W),
        .ROW_PITCH (ROW_PITCH)
    ) u_sweep (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .step  (sweep_step),
        .top_y (sweep_top_y),
        .x     (sweep_x),
        .y     (sweep_y),
        .last  (clear_last)
    );
`else
    // No blanking: CLEAR is never entered and the sweep width is unused.
    localparam int unused_screen_w = SCREEN_W;
    assign sweep_x    = '0;
    assign sweep_y    = '0;
    assign clear_last = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            slot        <= '0;
            colour      <= COLOUR_BLACK;
            draw_cnt    <= '0;
            timeout_err <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= COLOUR_BLACK;
            vga_plot    <= 1'b0;
        end else begin
            state    <= state_next;
            draw_cnt <= (state == ST_DRAW) ? draw_cnt + 1'b1 : '0;
            vga_plot <= 1'b0;

            if (accept) begin
                colour <= status_colour(txn_status);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (state == ST_FINISH) begin
                slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            end

            case (state)
                ST_CLEAR: begin
                    vga_x      <= sweep_x;
                    vga_y      <= sweep_y;
                    vga_colour <= COLOUR_BLACK;
                    vga_plot   <= 1'b1;
                end
                ST_DRAW: begin
                    vga_x      <= draw_x;
                    vga_y      <= draw_y;
                    vga_colour <= colour;
                    // Suppress the aborted cycle so FINISH never shows a plot.
                    vga_plot   <= !draw_done && !timeout_hit;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next  = state;
        txn_ready   = 1'b0;
        draw_resetn = 1'b1;
        draw_enable = 1'b0;
        busy        = 1'b1;
        unique case (state)
            ST_IDLE: begin
                txn_ready   = 1'b1;
                draw_resetn = 1'b0;
                busy        = 1'b0;
                if (accept) begin
`ifdef TXN_ROW_CLEAR_EN
                    state_next = ST_CLEAR;
`else
                    state_next = ST_ARM;
`endif
                end
            end
            ST_CLEAR: begin
                if (clear_last) state_next = ST_ARM;
            end
            ST_ARM: begin
                draw_resetn = 1'b0;
                state_next  = ST_DRAW;
            end
            ST_DRAW: begin
                draw_enable = 1'b1;
                if (draw_done || timeout_hit) state_next = ST_FINISH;
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_txn_draw_ctrl.sv
// tb_txn_draw_ctrl
//   Self-checking bench for txn_draw_ctrl. A behavioural drawer paints a
//   row 8 pixels wide from (0, origin-8); the bench predicts, per
//   transaction, the full list of plotted pixels, the slot origin and the
//   handshake/timing behaviour, and compares against what the DUT plots.
//   Honours TXN_ROW_CLEAR_EN for the row-blanking expectations.
module tb_txn_draw_ctrl;

    localparam int BASE_Y       = 24;
    localparam int ROW_PITCH    = 20;
    localparam int NUM_ROWS     = 10;
    localparam int SCREEN_W     = 320;
    localparam int DRAW_TIMEOUT = 4095;
    localparam int BUSY_LIMIT   = 20000;
    localparam int DRAW_W       = 8;
`ifdef TXN_ROW_CLEAR_EN
    localparam int N_RAND       = 1;
`else
    localparam int N_RAND       = 20;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       txn_valid;
    logic [1:0] txn_status;
    logic       txn_ready;
    logic       draw_resetn;
    logic       draw_enable;
    logic [8:0] draw_start_x;
    logic [7:0] draw_start_y;
    logic [8:0] draw_x;
    logic [7:0] draw_y;
    logic       draw_done = 1'b0;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       timeout_err;

    always #5 clk = ~clk;

    txn_draw_ctrl #(
        .BASE_Y       (BASE_Y),
        .ROW_PITCH    (ROW_PITCH),
        .NUM_ROWS     (NUM_ROWS),
        .SCREEN_W     (SCREEN_W),
        .DRAW_TIMEOUT (DRAW_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .txn_valid    (txn_valid),
        .txn_status   (txn_status),
        .txn_ready    (txn_ready),
        .draw_resetn  (draw_resetn),
        .draw_enable  (draw_enable),
        .draw_start_x (draw_start_x),
        .draw_start_y (draw_start_y),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .draw_done    (draw_done),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // Behavioural drawer: one pixel per enabled cycle, done is sticky until
    // draw_resetn re-arms it.
    int drawer_len = 16;
    int dcnt = 0;
    always @(posedge clk) begin
        if (!draw_resetn) begin
            dcnt      <= 0;
            draw_done <= 1'b0;
        end else if (draw_enable && !draw_done) begin
            dcnt <= dcnt + 1;
            if (dcnt == drawer_len - 1) draw_done <= 1'b1;
        end
    end
    assign draw_x = 9'(dcnt % DRAW_W);
    assign draw_y = 8'(int'(draw_start_y) - 8 + dcnt / DRAW_W);

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic [2:0] colour_of(input logic [1:0] st);
        case (st)
            2'd0:    return 3'b110;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    // Reference state
    int ref_slot = 0;
    bit exp_err  = 1'b0;

    function automatic int slot_y(input int s);
        return BASE_Y + s * ROW_PITCH;
    endfunction

    // Runs one transaction from the current negedge until the DUT is idle again.
    task automatic run_txn(input logic [1:0] st, input int len, input logic [2:0] exp_col,
                           input int exp_y0, input bit exp_timeout,
                           input bit keep_valid, input logic [1:0] st_after);
        logic [19:0] got_q[$];
        logic [19:0] exp_q[$];
        int n, cyc, rn_low, ready_busy, draw_cyc, done_cyc, mm;
        logic [7:0] seen_y;

        drawer_len = len;
        txn_valid  = 1'b1;
        txn_status = st;
        n = 0;
        while (!txn_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait_bound", 32'(n < 100), 32'd1);
        @(negedge clk);
        if (!keep_valid) txn_valid = 1'b0;
        txn_status = st_after;

        cyc = 0; rn_low = 0; ready_busy = 0; draw_cyc = 0; done_cyc = -1;
        seen_y = 8'hxx;
        while (busy && cyc < BUSY_LIMIT) begin
            cyc++;
            if (vga_plot) got_q.push_back({vga_x, vga_y, vga_colour});
            if (!draw_resetn) rn_low++;
            if (txn_ready) ready_busy++;
            if (draw_enable) begin
                draw_cyc++;
                seen_y = draw_start_y;
                if (draw_done && done_cyc < 0) done_cyc = cyc;
            end
            @(negedge clk);
        end

        check("busy_bound", 32'(cyc < BUSY_LIMIT), 32'd1);
        check("draw_resetn_low_cycles", 32'(rn_low), 32'd1);
        check("ready_while_busy", 32'(ready_busy), 32'd0);
        check("draw_start_y", 32'(seen_y), 32'(exp_y0));

        if (exp_timeout) begin
            check("timeout_draw_cycles", 32'(draw_cyc), 32'(DRAW_TIMEOUT));
            check("timeout_err_set", 32'(timeout_err), 32'd1);
            exp_err = 1'b1;
        end else begin
`ifdef TXN_ROW_CLEAR_EN
            for (int y = 0; y < ROW_PITCH; y++)
                for (int x = 0; x < SCREEN_W; x++)
                    exp_q.push_back({9'(x), 8'(exp_y0 - 8 + y), 3'b000});
`endif
            for (int i = 0; i < len; i++)
                exp_q.push_back({9'(i % DRAW_W), 8'(exp_y0 - 8 + i / DRAW_W), exp_col});
            check("pixel_count", 32'(got_q.size()), 32'(exp_q.size()));
            mm = -1;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                if (mm < 0 && got_q[i] !== exp_q[i]) mm = i;
            end
            if (mm >= 0) $display("  pixel %0d differs: got %h want %h", mm, got_q[mm], exp_q[mm]);
            check("pixel_first_diff_index", 32'(mm), 32'hffff_ffff);
            check("done_to_idle_cycles", 32'(cyc + 1 - done_cyc), 32'd2);
            check("timeout_err_sticky", 32'(timeout_err), 32'(exp_err));
        end
        ref_slot = (ref_slot + 1) % NUM_ROWS;
    endtask

    typedef struct {
        logic [1:0] status;
        int         len;
        logic [2:0] col;
        int         y0;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [1:0] st;
        int len;

        vecs[0]  = '{2'd1,  9, 3'b010,  24};
        vecs[1]  = '{2'd0,  1, 3'b110,  44};
        vecs[2]  = '{2'd2, 16, 3'b100,  64};
        vecs[3]  = '{2'd3,  8, 3'b111,  84};
        vecs[4]  = '{2'd1, 17, 3'b010, 104};
        vecs[5]  = '{2'd2,  3, 3'b100, 124};
        vecs[6]  = '{2'd0, 24, 3'b110, 144};
        vecs[7]  = '{2'd3,  5, 3'b111, 164};
        vecs[8]  = '{2'd3, 12, 3'b111, 184};
        vecs[9]  = '{2'd1,  2, 3'b010, 204};
        vecs[10] = '{2'd0,  7, 3'b110,  24};

        reset      = 1'b1;
        txn_valid  = 1'b0;
        txn_status = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_txn_ready",    32'(txn_ready),    32'd1);
        check("rst_vga_plot",     32'(vga_plot),     32'd0);
        check("rst_draw_resetn",  32'(draw_resetn),  32'd0);
        check("rst_draw_enable",  32'(draw_enable),  32'd0);
        check("rst_timeout_err",  32'(timeout_err),  32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_vga_xyc",      32'({vga_x, vga_y, vga_colour}), 32'd0);
        check("rst_draw_start_x", 32'(draw_start_x), 32'd0);
        check("rst_draw_start_y", 32'(draw_start_y), 32'd24);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back over every slot and the wrap to slot 0.
        for (int i = 0; i < 11; i++)
            run_txn(vecs[i].status, vecs[i].len, vecs[i].col, vecs[i].y0, 1'b0, 1'b0, 2'd0);

        // Valid held through a transaction with status changing after accept.
        run_txn(2'd1, 10, 3'b010, slot_y(ref_slot), 1'b0, 1'b1, 2'd2);
        run_txn(2'd2,  6, 3'b100, slot_y(ref_slot), 1'b0, 1'b0, 2'd0);

        // Randomized transactions with idle gaps.
        for (int i = 0; i < N_RAND; i++) begin
            st  = 2'($urandom_range(0, 3));
            len = int'($urandom_range(1, 40));
            run_txn(st, len, colour_of(st), slot_y(ref_slot), 1'b0, 1'b0, 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Drawer that never finishes.
        run_txn(2'd3, 1000000, 3'b111, slot_y(ref_slot), 1'b1, 1'b0, 2'd0);
        check("timeout_back_idle", 32'(txn_ready), 32'd1);
        check("timeout_slot_advanced", 32'(draw_start_y), 32'(slot_y(ref_slot)));
        run_txn(2'd0, 4, 3'b110, slot_y(ref_slot), 1'b0, 1'b0, 2'd0);

        // Reset in the middle of a transaction.
        drawer_len = 1000000;
        txn_valid  = 1'b1;
        txn_status = 2'd1;
        @(negedge clk);
        txn_valid = 1'b0;
`ifdef TXN_ROW_CLEAR_EN
        repeat (100) @(negedge clk);
        check("mid_clear_plotting", 32'(vga_plot), 32'd1);
`else
        repeat (20) @(negedge clk);
        check("mid_draw_enabled", 32'(draw_enable), 32'd1);
`endif
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_vga_plot",     32'(vga_plot),     32'd0);
        check("abort_busy",         32'(busy),         32'd0);
        check("abort_txn_ready",    32'(txn_ready),    32'd1);
        check("abort_draw_enable",  32'(draw_enable),  32'd0);
        check("abort_timeout_err",  32'(timeout_err),  32'd0);
        check("abort_draw_start_y", 32'(draw_start_y), 32'd24);
        reset    = 1'b0;
        exp_err  = 1'b0;
        ref_slot = 0;
        @(negedge clk);
        run_txn(2'd2, 10, 3'b100, 24, 1'b0, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
